// File: rtl/pipelined_shifter.sv
// Fully pipelined barrel shifter (SLL/SRL/SRA/ROR), one power-of-two level per stage with valid/ready.
// Define PIPELINED_SHIFTER_ROTATE_EN to build rotate-right for op 11; otherwise op 11 behaves as SRL.
module pipelined_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic             valid_r [SHW];
    logic [WIDTH-1:0] data_r  [SHW];
    logic [SHW-1:0]   shamt_r [SHW];
    logic [1:0]       op_r    [SHW];
    logic [TAG_W-1:0] tag_r   [SHW];
    logic             sign_r  [SHW];

    logic             ready_s     [SHW];
    logic             src_valid_s [SHW];
    logic [WIDTH-1:0] src_data_s  [SHW];
    logic [SHW-1:0]   src_shamt_s [SHW];
    logic [1:0]       src_op_s    [SHW];
    logic [TAG_W-1:0] src_tag_s   [SHW];
    logic             src_sign_s  [SHW];
    logic [WIDTH-1:0] lvl_data_s  [SHW];
    logic             in_ready_s;

    // One shift level of 2**lvl positions, applied only when its shamt bit is set.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input int               lvl,
        input logic [1:0]       op,
        input logic             sign
    );
        int               amt;
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] res;
        amt  = 1 << lvl;
        fill = ~({WIDTH{1'b1}} >> amt);
        if (!en) begin
            res = d;
        end else begin
            case (op)
                2'b00:   res = d << amt;
                2'b01:   res = d >> amt;
                2'b10:   res = (d >> amt) | (sign ? fill : {WIDTH{1'b0}});
`ifdef PIPELINED_SHIFTER_ROTATE_EN
                2'b11:   res = (d >> amt) | (d << (WIDTH - amt));
`else
                2'b11:   res = d >> amt;
`endif
                default: res = d;
            endcase
        end
        return res;
    endfunction

    // Stage k can load when empty or when the stage below it moves on.
    always_comb begin
        logic r;
        r = out_ready;
        for (int k = SHW - 1; k >= 0; k--) begin
            r = r || !valid_r[k];
            ready_s[k] = r;
        end
    end

    assign in_ready_s = ready_s[0] && !flush;

    // Per-stage source selection and the combinational level feeding each register.
    always_comb begin
        src_valid_s[0] = in_valid && in_ready_s;
        src_data_s[0]  = in_data;
        src_shamt_s[0] = in_shamt;
        src_op_s[0]    = in_op;
        src_tag_s[0]   = in_tag;
        src_sign_s[0]  = in_data[WIDTH-1];
        for (int k = 1; k < SHW; k++) begin
            src_valid_s[k] = valid_r[k-1];
            src_data_s[k]  = data_r[k-1];
            src_shamt_s[k] = shamt_r[k-1];
            src_op_s[k]    = op_r[k-1];
            src_tag_s[k]   = tag_r[k-1];
            src_sign_s[k]  = sign_r[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            lvl_data_s[k] = shift_level(src_data_s[k], src_shamt_s[k][SHW-1-k], SHW - 1 - k,
                                        src_op_s[k], src_sign_s[k]);
        end
    end

    // Pipeline registers: flush drops valids only; payload loads on an accepted transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SHW; k++) begin
                valid_r[k] <= 1'b0;
                data_r[k]  <= {WIDTH{1'b0}};
                shamt_r[k] <= {SHW{1'b0}};
                op_r[k]    <= 2'b00;
                tag_r[k]   <= {TAG_W{1'b0}};
                sign_r[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (flush) begin
                    valid_r[k] <= 1'b0;
                end else if (ready_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                end
                if (!flush && ready_s[k] && src_valid_s[k]) begin
                    data_r[k]  <= lvl_data_s[k];
                    shamt_r[k] <= src_shamt_s[k];
                    op_r[k]    <= src_op_s[k];
                    tag_r[k]   <= src_tag_s[k];
                    sign_r[k]  <= src_sign_s[k];
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_r[SHW-1];
    assign out_data  = data_r[SHW-1];
    assign out_tag   = tag_r[SHW-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed cases plus randomized traffic against a queue model.
module tb_pipelined_shifter;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SHW   = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    int total = 0;
    int bad = 0;
    int stall_left = 0;
    int recv_cnt = 0;
    int lat;
    logic rand_ready = 1'b0;
    logic saw_not_ready = 1'b0;
    logic last_acc;
    logic last_ov;
    logic [WIDTH-1:0] last_od;
    logic [WIDTH-1:0] exp_d[$];
    logic [TAG_W-1:0] exp_t[$];

    pipelined_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int sh,
                                                   input logic [1:0] op);
        logic signed [WIDTH-1:0] s;
        logic [2*WIDTH-1:0]      dd;
        case (op)
            2'b00: return d << sh;
            2'b01: return d >> sh;
            2'b10: begin
                s = d;
                s = s >>> sh;
                return s;
            end
            default: begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
                dd = {d, d} >> sh;
`else
                dd = {{WIDTH{1'b0}}, d} >> sh;
`endif
                return dd[WIDTH-1:0];
            end
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // One clock: sample mid-cycle, update the model, advance to the next negedge.
    task automatic step();
        #2;
        last_ov  = out_valid;
        last_od  = out_data;
        last_acc = 1'b0;
        if (out_valid) begin
            check("out_has_expected", 64'(exp_d.size() != 0), 64'd1);
            if (exp_d.size() != 0) begin
                check("out_data", 64'(out_data), 64'(exp_d[0]));
                check("out_tag", 64'(out_tag), 64'(exp_t[0]));
                if (out_ready) begin
                    void'(exp_d.pop_front());
                    void'(exp_t.pop_front());
                    recv_cnt++;
                end
            end
        end
        if (!in_ready) saw_not_ready = 1'b1;
        if (flush) begin
            check("in_ready_flush", 64'(in_ready), 64'd0);
            exp_d.delete();
            exp_t.delete();
        end else if (in_valid && in_ready) begin
            last_acc = 1'b1;
            exp_d.push_back(ref_shift(in_data, int'(in_shamt), in_op));
            exp_t.push_back(in_tag);
        end
        @(posedge clock);
        @(negedge clock);
        if (stall_left > 0) stall_left--;
        out_ready = (stall_left == 0) && (!rand_ready || ($urandom_range(0, 3) != 0));
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int sh, input logic [1:0] op,
                        input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = SHW'(sh);
        in_op    = op;
        in_tag   = tag;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // Issue one op into an idle pipe and return cycles until its result is visible.
    task automatic directed(input string nm, input logic [WIDTH-1:0] d, input int sh,
                            input logic [1:0] op, input logic [WIDTH-1:0] exp);
        send(d, sh, op, 4'(sh));
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (last_ov) break;
        end
        check({nm, "_data"}, 64'(last_od), 64'(exp));
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        stall_left = 0;
        out_ready  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_d.size() == 0 && !out_valid) break;
            step();
        end
        check("drain_empty", 64'(exp_d.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_op = 2'b00; in_tag = '0;
        @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        directed("sra_min", 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF);
        check("latency", 64'(lat), 64'(SHW));
        directed("sra_pos", 32'h7FFF_FFF0, 4, 2'b10, 32'h07FF_FFFF);
        directed("sll_31", 32'h0000_0001, 31, 2'b00, 32'h8000_0000);
        directed("srl_4", 32'hF000_0000, 4, 2'b01, 32'h0F00_0000);
        for (int op = 0; op < 4; op++)
            directed("shamt0", 32'hDEAD_BEEF, 0, 2'(op), 32'hDEAD_BEEF);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        directed("ror_1", 32'h0000_0001, 1, 2'b11, 32'h8000_0000);
        directed("ror_8", 32'h1234_5678, 8, 2'b11, 32'h7812_3456);
`else
        directed("ror_1", 32'h0000_0001, 1, 2'b11, 32'h0000_0000);
        directed("ror_8", 32'h1234_5678, 8, 2'b11, 32'h0012_3456);
`endif
        drain();

        // Stream of 20 with a 7-cycle output stall mid-stream.
        saw_not_ready = 1'b0;
        recv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) begin
                out_ready  = 1'b0;
                stall_left = 7;
            end
            send($urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)), 4'(i % 16));
        end
        drain();
        check("stall_in_ready_low", 64'(saw_not_ready), 64'd1);
        check("stream_count", 64'(recv_cnt), 64'd20);

        // Flush with three ops in flight, then a fresh op one cycle later.
        for (int i = 0; i < 3; i++) send($urandom, $urandom_range(0, 31), 2'b01, 4'(i));
        flush = 1'b1; in_valid = 1'b1; in_data = $urandom; in_tag = 4'hF;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        directed("post_flush", 32'h0000_00F0, 4, 2'b00, 32'h0000_0F00);
        check("post_flush_latency", 64'(lat), 64'(SHW));
        drain();

        // Async reset pulse between edges with a full pipeline.
        out_ready = 1'b0; stall_left = 100;
        for (int i = 0; i < SHW; i++) send(32'hFFFF_FFFF, 0, 2'b00, 4'hA);
        #1 reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_out_tag", 64'(out_tag), 64'd0);
        #1 reset = 1'b0;
        exp_d.delete(); exp_t.delete();
        stall_left = 0; out_ready = 1'b1;
        @(negedge clock);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        directed("post_reset", 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF);
        check("post_reset_latency", 64'(lat), 64'(SHW));
        drain();

        // Randomized traffic with random backpressure and rare flushes.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            in_shamt = SHW'($urandom_range(0, 31));
            in_op    = 2'($urandom_range(0, 3));
            in_tag   = TAG_W'($urandom);
            flush    = ($urandom_range(0, 59) == 0);
            step();
        end
        flush = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
